// File: rtl/cache_line_fill.sv
// Cache line fill controller: optional dirty-victim writeback, then a BEATS-word
// fetch into the selected way, then a one-cycle commit that validates the line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Miss; victim and miss info latched on acceptance
// WRITEBACK | writing the dirty victim line to the bus, one word per BusAck
// FETCH     | reading the missing line from the bus into the array
// COMMIT    | single cycle: mark line valid/clean, update LRU, pulse Done
module cache_line_fill #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int TAGLEN   = 20,
  parameter int WORDLEN  = 64,
  parameter int BEATS    = 4,
  parameter int LOGBEATS = $clog2(BEATS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Miss,
  input  logic [SETLEN-1:0]                   MissSet,
  input  logic [TAGLEN-1:0]                   MissTag,
  input  logic [NUMWAYS-1:0]                  VictimWay,
  input  logic                                VictimDirty,
  input  logic [TAGLEN-1:0]                   VictimTag,
  input  logic [WORDLEN-1:0]                  ArrayRData,
  input  logic                                BusAck,
  input  logic [WORDLEN-1:0]                  BusRData,
  output logic                                BusReq,
  output logic                                BusWrite,
  output logic [TAGLEN+SETLEN+LOGBEATS-1:0]   BusAdr,
  output logic [WORDLEN-1:0]                  BusWData,
  output logic [NUMWAYS-1:0]                  SelWay,
  output logic [LOGBEATS-1:0]                 ArrayWordIdx,
  output logic                                ArrayWrEn,
  output logic [WORDLEN-1:0]                  ArrayWData,
  output logic                                SetValid,
  output logic                                LRUWriteEn,
  output logic                                Busy,
  output logic                                Done
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, COMMIT} state_t;

  localparam logic [LOGBEATS-1:0] LAST_BEAT = LOGBEATS'(BEATS - 1);

  state_t              state, state_nxt;
  logic [LOGBEATS-1:0] beat, beat_nxt;
  logic [SETLEN-1:0]   set_q;
  logic [TAGLEN-1:0]   tag_q;
  logic [TAGLEN-1:0]   vtag_q;
  logic [NUMWAYS-1:0]  way_q;
  logic                dirty_q;
  logic                accept;

  assign accept = (state == IDLE) && Miss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beat    <= '0;
      set_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (accept) begin
        set_q   <= MissSet;
        tag_q   <= MissTag;
        vtag_q  <= VictimTag;
        way_q   <= VictimWay;
        dirty_q <= VictimDirty;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    BusReq       = 1'b0;
    BusWrite     = 1'b0;
    BusAdr       = '0;
    BusWData     = '0;
    SelWay       = '0;
    ArrayWordIdx = beat;
    ArrayWrEn    = 1'b0;
    ArrayWData   = '0;
    SetValid     = 1'b0;
    LRUWriteEn   = 1'b0;
    Busy         = (state != IDLE);
    Done         = 1'b0;

    case (state)
      IDLE: begin
        if (Miss) begin
          beat_nxt  = '0;
          state_nxt = VictimDirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BusReq   = 1'b1;
        BusWrite = dirty_q;
        BusAdr   = {vtag_q, set_q, beat};
        BusWData = ArrayRData;
        SelWay   = way_q;
        if (BusAck) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = FETCH;
          end else begin
            beat_nxt = beat + LOGBEATS'(1);
          end
        end
      end
      FETCH: begin
        BusReq = 1'b1;
        BusAdr = {tag_q, set_q, beat};
        SelWay = way_q;
        if (BusAck) begin
          ArrayWrEn  = 1'b1;
          ArrayWData = BusRData;
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = COMMIT;
          end else begin
            beat_nxt = beat + LOGBEATS'(1);
          end
        end
      end
      COMMIT: begin
        SelWay     = way_q;
        SetValid   = 1'b1;
        LRUWriteEn = 1'b1;
        Done       = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: a transfer-list model predicts every output
// each cycle; literal checks pin latency, addresses and boundary behaviour.
module tb_cache_line_fill;
  localparam int NUMWAYS = 4, SETLEN = 9, TAGLEN = 20, WORDLEN = 64, BEATS = 4, LOGBEATS = 2;
  localparam int AW = TAGLEN + SETLEN + LOGBEATS;

  logic clk = 1'b0, reset = 1'b0;
  logic Miss = 1'b0, VictimDirty = 1'b0, BusAck = 1'b0;
  logic [SETLEN-1:0] MissSet = '0;
  logic [TAGLEN-1:0] MissTag = '0, VictimTag = '0;
  logic [NUMWAYS-1:0] VictimWay = '0;
  logic [WORDLEN-1:0] ArrayRData, BusRData = '0;
  logic BusReq, BusWrite, ArrayWrEn, SetValid, LRUWriteEn, Busy, Done;
  logic [AW-1:0] BusAdr;
  logic [WORDLEN-1:0] BusWData, ArrayWData;
  logic [NUMWAYS-1:0] SelWay;
  logic [LOGBEATS-1:0] ArrayWordIdx;

  cache_line_fill dut (
    .clk(clk), .reset(reset), .Miss(Miss), .MissSet(MissSet), .MissTag(MissTag),
    .VictimWay(VictimWay), .VictimDirty(VictimDirty), .VictimTag(VictimTag),
    .ArrayRData(ArrayRData), .BusAck(BusAck), .BusRData(BusRData),
    .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWData(BusWData),
    .SelWay(SelWay), .ArrayWordIdx(ArrayWordIdx), .ArrayWrEn(ArrayWrEn),
    .ArrayWData(ArrayWData), .SetValid(SetValid), .LRUWriteEn(LRUWriteEn),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  function automatic logic [WORDLEN-1:0] arr_word(input int idx);
    return 64'hA5A5_5A5A_0000_0000 + 64'(idx) * 64'h101;
  endfunction

  assign ArrayRData = arr_word(int'(ArrayWordIdx));

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: a fill is an ordered list of bus transfers; each BusAck consumes one,
  // and once the list is exhausted a single commit cycle follows.
  bit m_busy = 0;
  int m_k = 0, m_n = 0;
  bit m_xw [2*BEATS];
  logic [AW-1:0] m_xadr [2*BEATS];
  logic [NUMWAYS-1:0] m_way = '0;

  always @(negedge reset) begin
    m_busy = 0; m_k = 0; m_n = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      if (!m_busy) begin
        if (Miss) begin
          m_n = 0;
          if (VictimDirty)
            for (int i = 0; i < BEATS; i++) begin
              m_xw[m_n] = 1; m_xadr[m_n] = {VictimTag, MissSet, LOGBEATS'(i)}; m_n++;
            end
          for (int i = 0; i < BEATS; i++) begin
            m_xw[m_n] = 0; m_xadr[m_n] = {MissTag, MissSet, LOGBEATS'(i)}; m_n++;
          end
          m_way = VictimWay; m_k = 0; m_busy = 1;
        end
      end else if (m_k < m_n) begin
        if (BusAck) m_k++;
      end else begin
        m_busy = 0;
      end
    end
  end

  logic e_req, e_wr, e_wen, e_commit, e_busy;
  logic [AW-1:0] e_adr;
  logic [WORDLEN-1:0] e_wdata, e_adata;
  logic [NUMWAYS-1:0] e_way;
  int e_idx;

  always @(negedge clk) begin
    e_req = 0; e_wr = 0; e_wen = 0; e_commit = 0; e_busy = 0;
    e_adr = '0; e_wdata = '0; e_adata = '0; e_way = '0; e_idx = 0;
    if (reset && m_busy) begin
      e_busy = 1; e_way = m_way;
      if (m_k < m_n) begin
        e_req = 1; e_wr = m_xw[m_k]; e_adr = m_xadr[m_k]; e_idx = m_k % BEATS;
        if (e_wr) e_wdata = arr_word(e_idx);
        else if (BusAck) begin e_wen = 1; e_adata = BusRData; end
      end else begin
        e_commit = 1;
      end
    end
    chk("BusReq", 64'(BusReq), 64'(e_req));
    chk("BusWrite", 64'(BusWrite), 64'(e_wr));
    chk("BusAdr", 64'(BusAdr), 64'(e_adr));
    chk("BusWData", BusWData, e_wdata);
    chk("SelWay", 64'(SelWay), 64'(e_way));
    chk("ArrayWordIdx", 64'(ArrayWordIdx), 64'(e_idx));
    chk("ArrayWrEn", 64'(ArrayWrEn), 64'(e_wen));
    chk("ArrayWData", ArrayWData, e_adata);
    chk("SetValid", 64'(SetValid), 64'(e_commit));
    chk("LRUWriteEn", 64'(LRUWriteEn), 64'(e_commit));
    chk("Done", 64'(Done), 64'(e_commit));
    chk("Busy", 64'(Busy), 64'(e_busy));
  end

  always @(posedge clk) BusRData <= 64'hF00D_0000_0000_0000 | 64'(cyc);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_fill(input logic [TAGLEN-1:0] tag, input logic [SETLEN-1:0] set,
                            input logic [NUMWAYS-1:0] way, input logic dirty,
                            input logic [TAGLEN-1:0] vtag, output int t0);
    Miss = 1; MissTag = tag; MissSet = set; VictimWay = way;
    VictimDirty = dirty; VictimTag = vtag; t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int lat, input string nm);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (Done) begin seen = 1; chk(nm, 64'(cyc - t0), 64'(lat)); end
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  int t0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_busreq", 64'(BusReq), 64'd0);

    // clean fill, accepted on the first edge after reset release
    step();
    reset = 1; BusAck = 1;
    start_fill(20'h12345, 9'h1A, 4'b0100, 1'b0, 20'h0, t0);
    step(); Miss = 0;
    @(negedge clk);
    chk("clean_adr0", 64'(BusAdr), 64'h091A2868);
    chk("clean_selway", 64'(SelWay), 64'h4);
    chk("clean_wren", 64'(ArrayWrEn), 64'd1);
    wait_done(t0, 5, "clean_latency");

    // dirty fill
    step();
    start_fill(20'h13579, 9'h1A, 4'b0010, 1'b1, 20'h0ABCD, t0);
    step(); Miss = 0;
    @(negedge clk);
    chk("dirty_buswrite", 64'(BusWrite), 64'd1);
    chk("dirty_adr0", 64'(BusAdr), 64'h055E6868);
    chk("dirty_wdata0", BusWData, 64'hA5A5_5A5A_0000_0000);
    wait_done(t0, 9, "dirty_latency");

    // stall on fetch beat 2
    step();
    start_fill(20'h0F0F0, 9'h155, 4'b1000, 1'b0, 20'h0, t0);
    step(); Miss = 0;
    step(); step(); BusAck = 0;
    @(negedge clk);
    chk("stall_beat", 64'(BusAdr[1:0]), 64'd2);
    chk("stall_wren", 64'(ArrayWrEn), 64'd0);
    repeat (3) step();
    BusAck = 1;
    wait_done(t0, 8, "stall_latency");

    // Miss during FETCH and COMMIT ignored; held Miss accepted in next IDLE
    step();
    start_fill(20'h00111, 9'h003, 4'b0001, 1'b0, 20'h0, t0);
    step(); Miss = 0;
    step(); step(); Miss = 1; MissTag = 20'h77777; VictimDirty = 1;
    step(); Miss = 0; VictimDirty = 0;
    step(); Miss = 1; MissTag = 20'h22222; VictimWay = 4'b1000;
    @(negedge clk);
    chk("commit_done", 64'(Done), 64'd1);
    step();
    @(negedge clk);
    chk("post_commit_idle", 64'(Busy), 64'd0);
    t0 = cyc;
    step(); Miss = 0;
    @(negedge clk);
    chk("held_miss_busy", 64'(Busy), 64'd1);
    chk("held_miss_tag", 64'(BusAdr[AW-1 -: TAGLEN]), 64'h22222);
    wait_done(t0, 5, "held_latency");

    // reset on writeback beat 1 aborts the fill
    step();
    start_fill(20'h33333, 9'h044, 4'b0100, 1'b1, 20'h0ABCD, t0);
    step(); Miss = 0;
    step();
    reset = 0;
    #1;
    chk("abort_busreq", 64'(BusReq), 64'd0);
    chk("abort_adr", 64'(BusAdr), 64'd0);
    chk("abort_selway", 64'(SelWay), 64'd0);
    repeat (2) step();
    reset = 1;
    start_fill(20'h44444, 9'h0AA, 4'b0001, 1'b0, 20'h0, t0);
    step(); Miss = 0;
    wait_done(t0, 5, "after_reset_latency");

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
